// File: rtl/life_grid_engine.sv
// Game-of-Life grid engine: cells are programmed one at a time from two buttons, then evolved
// one generation per enabled cycle. The engine halts on its own at extinction or still life.
module life_grid_engine #(
    parameter int ROWS  = 7,
    parameter int COLS  = 7,
    parameter int WRAP  = 0,
    parameter int GEN_W = 16,
    localparam int CELLS = ROWS * COLS,
    localparam int IDX_W = $clog2(CELLS)
) (
    input  logic             clka,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             btn0,
    input  logic             btn1,
    input  logic             stop,
    output logic [CELLS-1:0] grid,
    output logic [IDX_W-1:0] cursor,
    output logic [GEN_W-1:0] gen_count,
    output logic             extinct,
    output logic             stable,
    output logic             halted
);

    typedef enum logic [1:0] {S_IDLE, S_PROG, S_RUN, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   grid_q, grid_d;
    logic [IDX_W-1:0]   cursor_q, cursor_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic               extinct_q, extinct_d;
    logic               stable_q, stable_d;
    logic               halted_q, halted_d;
    logic               btn0_q, btn0_d;
    logic               btn1_q, btn1_d;
    logic               btn0_edge, btn1_edge;
    logic               step_en;
    logic [CELLS-1:0]   next_grid;

    // Every cell reads the registered grid, so the whole generation changes in one step.
    function automatic logic [CELLS-1:0] life_step(input logic [CELLS-1:0] cur);
        logic [CELLS-1:0] nxt;
        logic [3:0]       cnt;
        logic [IDX_W-1:0] idx;
        int               rr;
        int               cc;
        nxt = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 4'd0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (WRAP != 0) begin
                            if (rr < 0) rr = ROWS - 1;
                            else if (rr >= ROWS) rr = 0;
                            if (cc < 0) cc = COLS - 1;
                            else if (cc >= COLS) cc = 0;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                            idx = IDX_W'(rr * COLS + cc);
                            cnt = cnt + {3'd0, cur[idx]};
                        end
                    end
                end
                idx = IDX_W'(r * COLS + c);
                nxt[idx] = (cnt == 4'd3) || (cur[idx] && cnt == 4'd2);
            end
        end
        return nxt;
    endfunction

    always_comb begin
        btn0_d    = btn0;
        btn1_d    = btn1;
        btn0_edge = btn0 & ~btn0_q;
        btn1_edge = btn1 & ~btn1_q;
        next_grid = life_step(grid_q);
        state_d   = state_q;
        grid_d    = grid_q;
        cursor_d  = cursor_q;
        gen_d     = gen_q;
        extinct_d = extinct_q;
        stable_d  = stable_q;
        step_en   = 1'b0;

        if (stop) begin
            state_d   = S_IDLE;
            grid_d    = '0;
            cursor_d  = '0;
            gen_d     = '0;
            extinct_d = 1'b0;
            stable_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode == 2'b01) state_d = S_PROG;
                    else if (mode[1]) state_d = S_RUN;
                end
                S_PROG: begin
                    // Two simultaneous edges are ambiguous and are dropped entirely.
                    if (mode == 2'b01) begin
                        if (btn0_edge ^ btn1_edge) begin
                            grid_d[cursor_q] = btn1_edge;
                            cursor_d = (cursor_q == IDX_W'(CELLS - 1)) ? '0 : cursor_q + 1'b1;
                        end
                    end else if (mode[1]) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    case (mode)
                        2'b00: state_d = S_IDLE;
                        2'b01: state_d = S_PROG;
                        2'b10: step_en = 1'b1;
                        2'b11: step_en = btn1_edge;
                    endcase
                    if (step_en) begin
                        grid_d    = next_grid;
                        gen_d     = (gen_q == '1) ? gen_q : gen_q + 1'b1;
                        extinct_d = (next_grid == '0);
                        stable_d  = (next_grid == grid_q);
                        if (extinct_d || stable_d) state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (mode == 2'b00) begin
                        state_d = S_IDLE;
                    end else if (mode == 2'b01) begin
                        state_d   = S_PROG;
                        extinct_d = 1'b0;
                        stable_d  = 1'b0;
                    end
                end
            endcase
        end
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grid_q    <= '0;
            cursor_q  <= '0;
            gen_q     <= '0;
            extinct_q <= 1'b0;
            stable_q  <= 1'b0;
            halted_q  <= 1'b0;
            btn0_q    <= 1'b0;
            btn1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            cursor_q  <= cursor_d;
            gen_q     <= gen_d;
            extinct_q <= extinct_d;
            stable_q  <= stable_d;
            halted_q  <= halted_d;
            btn0_q    <= btn0_d;
            btn1_q    <= btn1_d;
        end
    end

    assign grid      = grid_q;
    assign cursor    = cursor_q;
    assign gen_count = gen_q;
    assign extinct   = extinct_q;
    assign stable    = stable_q;
    assign halted    = halted_q;

endmodule
